// File: rtl/code_conv_sched.sv
// -----------------------------------------------------------------------------
// code_conv_sched
//   Round-robin scheduler in front of one shared binary/gray code converter.
//   Four requesters compete for the converter. One request is in flight at a
//   time: IDLE grants, CONV computes, RESP holds the result until the consumer
//   takes it.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   en         : permits new grants (sampled only in IDLE)
//   req_valid  : per-requester request present
//   req_mode   : per-requester mode, 1 = gray->binary, 0 = binary->gray
//   req_data   : per-requester code word, requester i at [i*WIDTH +: WIDTH]
//   req_ready  : one-hot grant, combinational in IDLE
//   rsp_valid  : result presented
//   rsp_ready  : consumer accepts result
//   rsp_id     : owning requester of the result
//   rsp_mode   : mode used for the result
//   rsp_data   : converted word
//   busy       : 1 whenever not IDLE
// -----------------------------------------------------------------------------
module code_conv_sched #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [3:0]         req_valid,
  input  logic [3:0]         req_mode,
  input  logic [4*WIDTH-1:0] req_data,
  output logic [3:0]         req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [1:0]         rsp_id,
  output logic               rsp_mode,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  logic [1:0]         last_grant;

  logic [WIDTH-1:0]   conv_data_p0;
  logic               conv_mode_p0;
  logic [1:0]         conv_id_p0;

  logic               grant_hit;
  logic [1:0]         grant_idx;
  logic [1:0]         cand;
  logic [WIDTH-1:0]   sel_data;
  logic               sel_mode;
  logic               accept;

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the running XOR of the gray bits from the MSB down.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int k = WIDTH - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  // Search starts one past the last accepted requester and wraps; the 2-bit
  // add gives the mod-4 wrap for free, and k=4 lands back on last_grant.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!grant_hit && req_valid[cand]) begin
        grant_hit = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_mode = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (grant_idx == 2'(k)) begin
        sel_data = req_data[k*WIDTH +: WIDTH];
        sel_mode = req_mode[k];
      end
    end
  end

  // rst gates the grant so nothing is accepted while reset is held.
  assign accept    = (state == IDLE) && en && grant_hit && !rst;
  assign req_ready = accept ? (4'b0001 << grant_idx) : 4'b0000;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 2'd3;
      rsp_valid  <= 1'b0;
      rsp_id     <= 2'd0;
      rsp_mode   <= 1'b0;
      rsp_data   <= '0;
    end else begin
      case (state)
        // Stage p0: capture the granted word, mode and owner.
        IDLE: begin
          if (accept) begin
            conv_data_p0 <= sel_data;
            conv_mode_p0 <= sel_mode;
            conv_id_p0   <= grant_idx;
            last_grant   <= grant_idx;
            state        <= CONV;
          end
        end
        // Stage p1: single shared conversion, registered into the result.
        CONV: begin
          rsp_data  <= conv_mode_p0 ? gray2bin(conv_data_p0) : bin2gray(conv_data_p0);
          rsp_mode  <= conv_mode_p0;
          rsp_id    <= conv_id_p0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        // Stage p2: hold until the consumer takes the result.
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
